lift_motion_ctrl: RTL and testbench
===================================

# lift_motion_ctrl

Floor-scheduling controller for the elevator car drive. It latches hall and car calls and picks a travel direction using SCAN: keep going the same way while calls lie ahead, otherwise reverse. It drives the stepper driver's `Dir`/`StepEnable` inputs, tracks car position by counting step periods, and runs a timed door-open dwell at each served floor. It sits between the call buttons and the stepper driver. Its step-period timer is matched to the driver's step lockout.

## Interface

Parameters:
- FLOORS, 4: number of floors; floor 0 is the bottom.
- FLOOR_W, 2: width of the floor index, equal to ceil(log2(FLOORS)).
- STEP_DIV, 200001: clock cycles per motor step. This must equal the driver's lockout period, which is lockout + 1.
- STEPS_PER_FLOOR, 512: motor steps between adjacent floors.
- DOOR_TIME, 750000: clock cycles the door stays open.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset. One clock; reset is asynchronous and active-low.
- call, in, FLOORS: call request, one bit per floor. Level or pulse; any cycle high registers the call.
- dir, out, 1: motor direction. 1 = down, 0 = up. Connects to the driver's `Dir`.
- step_en, out, 1: motor run enable. Connects to the driver's `StepEnable`.
- cur_floor, out, FLOOR_W: current or last-passed floor.
- moving, out, 1: car is travelling.
- door_open, out, 1: door dwell is active.
- pending, out, FLOORS: registered outstanding calls.

## Operation

- All outputs are registered. Reset values:
  - state IDLE, dir 0, step_en 0, cur_floor 0, moving 0, door_open 0, pending 0.
  - Internal counters and last_dir are reset to 0.
  - The car is treated as homed at floor 0.
- Pending calls:
  - Every cycle: pending <= pending | call, minus any bit cleared this cycle.
  - A clear wins over a set only for cur_floor while in DOOR.
- States: IDLE, UP, DOWN, DOOR.
- IDLE decision, evaluated on registered pending:
  - If pending[cur_floor] is set: go to DOOR and clear that bit.
  - Else if calls exist in last_dir's direction: keep last_dir.
  - Else if calls exist in the opposite direction: reverse and update last_dir.
  - Else: stay in IDLE.
  - Entering UP: dir = 0. Entering DOWN: dir = 1. Both set step_en = 1 and moving = 1, and zero the tick and step counters.
- UP/DOWN:
  - The tick counter counts 0..STEP_DIV-1. On wrap, step_cnt increments.
  - When step_cnt reaches STEPS_PER_FLOOR-1 and the tick wraps (the arrival cycle):
    - cur_floor moves ±1 and step_cnt returns to 0.
    - The stop test uses pending | call for the new floor.
  - Stop: step_en = 0, moving = 0, door_open = 1, clear that pending bit, go to DOOR. dir holds its value.
  - No stop: continue. Calls ahead are guaranteed, because an intermediate floor only exists when a farther call exists.
  - Floor bounds: UP is never entered at FLOORS-1 and DOWN is never entered at 0. cur_floor never wraps.
- DOOR:
  - The dwell counter counts DOOR_TIME cycles. The pending bit for cur_floor is held cleared, so calls at the open floor are absorbed.
  - On expiry: door_open = 0 and go to IDLE. The next decision happens one cycle later.
- Call changes while moving alter only stop decisions at later floors, never the current direction.
- Reset asserted mid-move or mid-dwell: all state returns to the reset values immediately (asynchronous). step_en drops with no completion of the current step.

## Timing

- Start latency: call rises before edge N, pending is set at edge N, state becomes UP/DOWN and step_en is high from edge N+1.
- Call at the current floor while in IDLE: door_open is high from edge N+1.
- Travel time per floor: exactly STEP_DIV*STEPS_PER_FLOOR cycles from step_en rising (or from the previous floor's arrival edge) to the arrival edge.
- Arrival with a stop: step_en falls and door_open rises on the arrival edge.
- Door dwell: door_open is high for exactly DOOR_TIME cycles.
- Pass-through: at an intermediate floor with no call, step_en never drops and cur_floor updates on the arrival edge.
- DOOR to IDLE takes 1 cycle. IDLE to motion takes 1 cycle.
- Idle-to-idle turnaround after a stop: DOOR_TIME + 1 cycles before the next motion.

## Test plan

Bench parameters: FLOORS=4, STEP_DIV=4, STEPS_PER_FLOOR=3, DOOR_TIME=10.

1. Reset, then a 1-cycle call[2] pulse:
   - step_en=1 and dir=0 from 2 edges after the call.
   - cur_floor becomes 1 after 12 cycles and 2 after 24, with no drop of step_en at floor 1.
   - At floor 2, door_open is high for 10 cycles, then the block idles with pending=0.
2. At floor 2, idle, call[2] held:
   - door_open goes high next edge and pending[2] stays 0.
   - call held through the dwell is absorbed, and the block returns to IDLE with no re-open.
3. Car moving up 0→3, call[1] asserted during the floor-0→1 leg before the arrival cycle:
   - The car stops at floor 1, dwells, then resumes up to floor 3 (last_dir up preferred).
4. SCAN reversal: car at floor 1 moving up to 3, call[0] asserted during travel:
   - The car serves 3, dwells, then goes dir=1 down to 0 without stopping at 2 or 1.
5. Simultaneous call[0] and call[3] while idle at floor 2 with last_dir=down:
   - The car goes down to 0 first, then up to 3.
6. rst asserted mid-leg while step_en=1:
   - All outputs go to 0 asynchronously.
   - After release, a call[0] opens the door with no motion.

Source files
------------

// File: rtl/lift_motion_ctrl.sv
// SCAN floor scheduler for a stepper-driven lift car: latches calls, picks travel
// direction, counts step periods to track position and times the door dwell.
module lift_motion_ctrl #(
  parameter int FLOORS          = 4,
  parameter int FLOOR_W         = 2,
  parameter int STEP_DIV        = 200001,
  parameter int STEPS_PER_FLOOR = 512,
  parameter int DOOR_TIME       = 750000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FLOORS-1:0]  call,
  output logic               dir,
  output logic               step_en,
  output logic [FLOOR_W-1:0] cur_floor,
  output logic               moving,
  output logic               door_open,
  output logic [FLOORS-1:0]  pending,
  output logic [1:0]         fsm_state
);

  localparam int TICK_W = $clog2(STEP_DIV + 1);
  localparam int STEP_W = $clog2(STEPS_PER_FLOOR + 1);
  localparam int DOOR_W = $clog2(DOOR_TIME + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    DOOR = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic               last_dir, last_dir_nxt;
  logic               dir_nxt, step_en_nxt, moving_nxt, door_open_nxt;
  logic [FLOOR_W-1:0] cur_floor_nxt, next_floor;
  logic [FLOORS-1:0]  pending_nxt, merged;
  logic [TICK_W-1:0]  tick_cnt, tick_nxt;
  logic [STEP_W-1:0]  step_cnt, step_nxt;
  logic [DOOR_W-1:0]  dwell_cnt, dwell_nxt;
  logic               above, below, at_end;
  logic               clr;
  logic [FLOOR_W-1:0] clr_floor;

  assign fsm_state = state;
  assign merged    = pending | call;

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (pending[i] && (i > int'(cur_floor))) above = 1'b1;
      if (pending[i] && (i < int'(cur_floor))) below = 1'b1;
    end
  end

  assign next_floor = (state == DOWN) ? cur_floor - FLOOR_W'(1) : cur_floor + FLOOR_W'(1);
  // End floors always stop the car, so cur_floor can never wrap.
  assign at_end = ((state == UP) && (next_floor == FLOOR_W'(FLOORS - 1))) ||
                  ((state == DOWN) && (next_floor == '0));

  always_comb begin
    state_nxt     = state;
    last_dir_nxt  = last_dir;
    dir_nxt       = dir;
    step_en_nxt   = step_en;
    moving_nxt    = moving;
    door_open_nxt = door_open;
    cur_floor_nxt = cur_floor;
    tick_nxt      = tick_cnt;
    step_nxt      = step_cnt;
    dwell_nxt     = dwell_cnt;
    clr           = 1'b0;
    clr_floor     = cur_floor;

    case (state)
      IDLE: begin
        if (pending[cur_floor]) begin
          state_nxt     = DOOR;
          door_open_nxt = 1'b1;
          dwell_nxt     = '0;
          clr           = 1'b1;
        end else if ((!last_dir && above) || (last_dir && below) || above || below) begin
          // Prefer last_dir; reverse only when nothing lies ahead.
          if ((!last_dir && above) || (!(last_dir && below) && above)) begin
            state_nxt    = UP;
            dir_nxt      = 1'b0;
            last_dir_nxt = 1'b0;
          end else begin
            state_nxt    = DOWN;
            dir_nxt      = 1'b1;
            last_dir_nxt = 1'b1;
          end
          step_en_nxt = 1'b1;
          moving_nxt  = 1'b1;
          tick_nxt    = '0;
          step_nxt    = '0;
        end
      end

      UP, DOWN: begin
        if (tick_cnt == TICK_W'(STEP_DIV - 1)) begin
          tick_nxt = '0;
          if (step_cnt == STEP_W'(STEPS_PER_FLOOR - 1)) begin
            step_nxt      = '0;
            cur_floor_nxt = next_floor;
            if (merged[next_floor] || at_end) begin
              state_nxt     = DOOR;
              step_en_nxt   = 1'b0;
              moving_nxt    = 1'b0;
              door_open_nxt = 1'b1;
              dwell_nxt     = '0;
              clr           = 1'b1;
              clr_floor     = next_floor;
            end
          end else begin
            step_nxt = step_cnt + STEP_W'(1);
          end
        end else begin
          tick_nxt = tick_cnt + TICK_W'(1);
        end
      end

      DOOR: begin
        // Calls at the open floor are absorbed for the whole dwell.
        clr = 1'b1;
        if (dwell_cnt == DOOR_W'(DOOR_TIME - 1)) begin
          state_nxt     = IDLE;
          door_open_nxt = 1'b0;
          dwell_nxt     = '0;
        end else begin
          dwell_nxt = dwell_cnt + DOOR_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase

    pending_nxt = pending | call;
    if (clr) pending_nxt[clr_floor] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last_dir  <= 1'b0;
      dir       <= 1'b0;
      step_en   <= 1'b0;
      moving    <= 1'b0;
      door_open <= 1'b0;
      cur_floor <= '0;
      pending   <= '0;
      tick_cnt  <= '0;
      step_cnt  <= '0;
      dwell_cnt <= '0;
    end else begin
      state     <= state_nxt;
      last_dir  <= last_dir_nxt;
      dir       <= dir_nxt;
      step_en   <= step_en_nxt;
      moving    <= moving_nxt;
      door_open <= door_open_nxt;
      cur_floor <= cur_floor_nxt;
      pending   <= pending_nxt;
      tick_cnt  <= tick_nxt;
      step_cnt  <= step_nxt;
      dwell_cnt <= dwell_nxt;
    end
  end

endmodule

// File: tb/tb_lift_motion_ctrl.sv
// Table-driven bench for lift_motion_ctrl: timed call records with expected output
// snapshots, plus a hand-written asynchronous reset sequence mid-leg.
module tb_lift_motion_ctrl;

  localparam int FLOORS = 4;
  localparam int FLOOR_W = 2;
  localparam int STEP_DIV = 4;
  localparam int STEPS_PER_FLOOR = 3;
  localparam int DOOR_TIME = 10;
  localparam int LEG = STEP_DIV * STEPS_PER_FLOOR;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;
  localparam logic [1:0] S_DOOR = 2'd3;

  logic               clk = 1'b0;
  logic               rst;
  logic [FLOORS-1:0]  call;
  logic               dir, step_en, moving, door_open;
  logic [FLOOR_W-1:0] cur_floor;
  logic [FLOORS-1:0]  pending;
  logic [1:0]         fsm_state;

  lift_motion_ctrl #(
    .FLOORS(FLOORS), .FLOOR_W(FLOOR_W), .STEP_DIV(STEP_DIV),
    .STEPS_PER_FLOOR(STEPS_PER_FLOOR), .DOOR_TIME(DOOR_TIME)
  ) dut (
    .clk(clk), .rst(rst), .call(call), .dir(dir), .step_en(step_en),
    .cur_floor(cur_floor), .moving(moving), .door_open(door_open),
    .pending(pending), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  call;
    int          hold;      // edges the call is held; 0 keeps it asserted
    int          wait_cyc;  // edges to advance before sampling
    bit          run;       // step_en must stay high on every intermediate cycle
    logic [11:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [11:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          reset_at;

  function automatic logic [11:0] snap();
    return {fsm_state, dir, step_en, cur_floor, moving, door_open, pending};
  endfunction

  task automatic check(input string nm, input logic [11:0] got, input logic [11:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got st=%0d dir=%b se=%b fl=%0d mv=%b door=%b pend=%b, expected st=%0d dir=%b se=%b fl=%0d mv=%b door=%b pend=%b",
               nm, got[11:10], got[9], got[8], got[7:6], got[5], got[4], got[3:0],
               want[11:10], want[9], want[8], want[7:6], want[5], want[4], want[3:0]);
    end
  endtask

  task automatic add(input string nm, input logic [3:0] c, input int h, input int w, input bit r,
                     input logic [1:0] st, input logic d, input logic se, input logic [1:0] fl,
                     input logic mv, input logic dr, input logic [3:0] pd);
    vec_t v;
    v.name = nm; v.call = c; v.hold = h; v.wait_cyc = w; v.run = r;
    v.exp = {st, d, se, fl, mv, dr, pd};
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    bit dropped;
    logic [11:0] want;
    dropped = 1'b0;
    call = v.call;
    exp_q.push_back(v.exp);
    for (int i = 0; i < v.wait_cyc; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (v.hold != 0 && i + 1 == v.hold) call = '0;
      if (v.run && (i + 1 < v.wait_cyc) && !step_en) dropped = 1'b1;
    end
    want = exp_q.pop_front();
    check(v.name, snap(), want);
    if (v.run) begin
      checks++;
      if (dropped) begin
        errors++;
        $display("FAIL %s_run: step_en dropped during leg, required steady 1", v.name);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    // name, call, hold, wait, run, state, dir, step_en, floor, moving, door, pending
    // T1: call[2] from floor 0, pass floor 1, serve 2.
    add("t1_latch",    4'b0100, 1, 1,  0, S_IDLE, 0, 0, 0, 0, 0, 4'b0100);
    add("t1_start",    4'b0000, 0, 1,  0, S_UP,   0, 1, 0, 1, 0, 4'b0100);
    add("t1_pre_f1",   4'b0000, 0, LEG-1, 1, S_UP, 0, 1, 0, 1, 0, 4'b0100);
    add("t1_pass_f1",  4'b0000, 0, 1,  0, S_UP,   0, 1, 1, 1, 0, 4'b0100);
    add("t1_pre_f2",   4'b0000, 0, LEG-1, 1, S_UP, 0, 1, 1, 1, 0, 4'b0100);
    add("t1_arrive",   4'b0000, 0, 1,  0, S_DOOR, 0, 0, 2, 0, 1, 4'b0000);
    add("t1_dwell",    4'b0000, 0, DOOR_TIME-1, 0, S_DOOR, 0, 0, 2, 0, 1, 4'b0000);
    add("t1_close",    4'b0000, 0, 1,  0, S_IDLE, 0, 0, 2, 0, 0, 4'b0000);
    add("t1_idle",     4'b0000, 0, 3,  0, S_IDLE, 0, 0, 2, 0, 0, 4'b0000);
    // T2: call at the current floor, held through most of the dwell.
    add("t2_latch",    4'b0100, 0, 1,  0, S_IDLE, 0, 0, 2, 0, 0, 4'b0100);
    add("t2_open",     4'b0100, 0, 1,  0, S_DOOR, 0, 0, 2, 0, 1, 4'b0000);
    add("t2_absorb",   4'b0100, 0, DOOR_TIME-2, 0, S_DOOR, 0, 0, 2, 0, 1, 4'b0000);
    add("t2_close",    4'b0000, 0, 2,  0, S_IDLE, 0, 0, 2, 0, 0, 4'b0000);
    add("t2_no_reopen",4'b0000, 0, 3,  0, S_IDLE, 0, 0, 2, 0, 0, 4'b0000);
    // Return to floor 0.
    add("dn_latch",    4'b0001, 1, 1,  0, S_IDLE, 0, 0, 2, 0, 0, 4'b0001);
    add("dn_start",    4'b0000, 0, 1,  0, S_DOWN, 1, 1, 2, 1, 0, 4'b0001);
    add("dn_pass_f1",  4'b0000, 0, LEG, 1, S_DOWN, 1, 1, 1, 1, 0, 4'b0001);
    add("dn_arrive",   4'b0000, 0, LEG, 1, S_DOOR, 1, 0, 0, 0, 1, 4'b0000);
    add("dn_close",    4'b0000, 0, DOOR_TIME, 0, S_IDLE, 1, 0, 0, 0, 0, 4'b0000);
    // T3: heading for 3, call[1] appears mid-leg.
    add("t3_latch",    4'b1000, 1, 1,  0, S_IDLE, 1, 0, 0, 0, 0, 4'b1000);
    add("t3_start",    4'b0000, 0, 1,  0, S_UP,   0, 1, 0, 1, 0, 4'b1000);
    add("t3_midcall",  4'b0010, 1, 5,  1, S_UP,   0, 1, 0, 1, 0, 4'b1010);
    add("t3_stop_f1",  4'b0000, 0, LEG-5, 0, S_DOOR, 0, 0, 1, 0, 1, 4'b1000);
    add("t3_close",    4'b0000, 0, DOOR_TIME, 0, S_IDLE, 0, 0, 1, 0, 0, 4'b1000);
    add("t3_resume",   4'b0000, 0, 1,  0, S_UP,   0, 1, 1, 1, 0, 4'b1000);
    // T4: call[0] behind the car; 3 served first, then straight down.
    add("t4_call0",    4'b0001, 1, 3,  1, S_UP,   0, 1, 1, 1, 0, 4'b1001);
    add("t4_pass_f2",  4'b0000, 0, LEG-3, 1, S_UP, 0, 1, 2, 1, 0, 4'b1001);
    add("t4_arrive3",  4'b0000, 0, LEG, 0, S_DOOR, 0, 0, 3, 0, 1, 4'b0001);
    add("t4_close",    4'b0000, 0, DOOR_TIME, 0, S_IDLE, 0, 0, 3, 0, 0, 4'b0001);
    add("t4_reverse",  4'b0000, 0, 1,  0, S_DOWN, 1, 1, 3, 1, 0, 4'b0001);
    add("t4_pass_f2d", 4'b0000, 0, LEG, 1, S_DOWN, 1, 1, 2, 1, 0, 4'b0001);
    add("t4_pass_f1d", 4'b0000, 0, LEG, 1, S_DOWN, 1, 1, 1, 1, 0, 4'b0001);
    add("t4_arrive0",  4'b0000, 0, LEG, 1, S_DOOR, 1, 0, 0, 0, 1, 4'b0000);
    add("t4_close",    4'b0000, 0, DOOR_TIME, 0, S_IDLE, 1, 0, 0, 0, 0, 4'b0000);
    // T5 setup: up to 3, then down to 2 so the last direction is down.
    add("t5_up_latch", 4'b1000, 1, 1,  0, S_IDLE, 1, 0, 0, 0, 0, 4'b1000);
    add("t5_up_start", 4'b0000, 0, 1,  0, S_UP,   0, 1, 0, 1, 0, 4'b1000);
    add("t5_up_arr",   4'b0000, 0, 3*LEG, 1, S_DOOR, 0, 0, 3, 0, 1, 4'b0000);
    add("t5_up_close", 4'b0000, 0, DOOR_TIME, 0, S_IDLE, 0, 0, 3, 0, 0, 4'b0000);
    add("t5_d2_latch", 4'b0100, 1, 1,  0, S_IDLE, 0, 0, 3, 0, 0, 4'b0100);
    add("t5_d2_start", 4'b0000, 0, 1,  0, S_DOWN, 1, 1, 3, 1, 0, 4'b0100);
    add("t5_d2_arr",   4'b0000, 0, LEG, 1, S_DOOR, 1, 0, 2, 0, 1, 4'b0000);
    add("t5_d2_close", 4'b0000, 0, DOOR_TIME, 0, S_IDLE, 1, 0, 2, 0, 0, 4'b0000);
    // T5: simultaneous call[0] and call[3]; down wins.
    add("t5_latch",    4'b1001, 1, 1,  0, S_IDLE, 1, 0, 2, 0, 0, 4'b1001);
    add("t5_go_down",  4'b0000, 0, 1,  0, S_DOWN, 1, 1, 2, 1, 0, 4'b1001);
    add("t5_arr0",     4'b0000, 0, 2*LEG, 1, S_DOOR, 1, 0, 0, 0, 1, 4'b1000);
    add("t5_close0",   4'b0000, 0, DOOR_TIME, 0, S_IDLE, 1, 0, 0, 0, 0, 4'b1000);
    add("t5_go_up",    4'b0000, 0, 1,  0, S_UP,   0, 1, 0, 1, 0, 4'b1000);
    add("t5_arr3",     4'b0000, 0, 3*LEG, 1, S_DOOR, 0, 0, 3, 0, 1, 4'b0000);
    add("t5_close3",   4'b0000, 0, DOOR_TIME, 0, S_IDLE, 0, 0, 3, 0, 0, 4'b0000);
    // T6: start a leg, reset hits mid-leg.
    add("t6_latch",    4'b0001, 1, 1,  0, S_IDLE, 0, 0, 3, 0, 0, 4'b0001);
    add("t6_start",    4'b0000, 0, 1,  0, S_DOWN, 1, 1, 3, 1, 0, 4'b0001);
    add("t6_midleg",   4'b0000, 0, 5,  1, S_DOWN, 1, 1, 3, 1, 0, 4'b0001);
    reset_at = vecs.size();
    add("t6_latch0",   4'b0001, 1, 1,  0, S_IDLE, 0, 0, 0, 0, 0, 4'b0001);
    add("t6_open0",    4'b0000, 0, 1,  0, S_DOOR, 0, 0, 0, 0, 1, 4'b0000);
    add("t6_close0",   4'b0000, 0, DOOR_TIME, 0, S_IDLE, 0, 0, 0, 0, 0, 4'b0000);
    add("t6_no_move",  4'b0000, 0, 3,  0, S_IDLE, 0, 0, 0, 0, 0, 4'b0000);

    // Clock/reset
    rst = 1'b0;
    call = '0;
    repeat (2) @(negedge clk);
    exp_q.push_back(12'h000);
    check("reset_hold", snap(), exp_q.pop_front());
    rst = 1'b1;
    @(negedge clk);
    exp_q.push_back(12'h000);
    check("reset_release", snap(), exp_q.pop_front());

    for (int i = 0; i < reset_at; i++) apply(vecs[i]);

    // Asynchronous reset between clock edges while step_en is high.
    #2 rst = 1'b0;
    #1;
    exp_q.push_back(12'h000);
    check("t6_async_reset", snap(), exp_q.pop_front());
    @(negedge clk);
    exp_q.push_back(12'h000);
    check("t6_reset_held", snap(), exp_q.pop_front());
    rst = 1'b1;

    for (int i = reset_at; i < vecs.size(); i++) apply(vecs[i]);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
